// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer for the multicycle core: drives PC/IR writes,
// the instruction memory request/response handshake and the decode handoff.
`timescale 1ns/1ps

module fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] pc_q,
    output logic [XLEN-1:0] pc_in,
    output logic            pc_wr,
    output logic [XLEN-1:0] ir_in,
    output logic            ir_wr,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fault,
    output logic            fault_cause
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t          state, state_n;
    logic            redir_pend, redir_pend_n;
    logic [XLEN-1:0] redir_pc, redir_pc_n;
    logic            squash, squash_n;
    logic            cause_q, cause_n;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_BOOT;
            redir_pend <= 1'b0;
            redir_pc   <= '0;
            squash     <= 1'b0;
            cause_q    <= 1'b0;
        end else begin
            state      <= state_n;
            redir_pend <= redir_pend_n;
            redir_pc   <= redir_pc_n;
            squash     <= squash_n;
            cause_q    <= cause_n;
        end
    end

    always_comb begin
        state_n       = state;
        redir_pend_n  = redir_pend;
        redir_pc_n    = redir_pc;
        squash_n      = squash;
        cause_n       = cause_q;
        pc_in         = pc_q;
        pc_wr         = 1'b0;
        ir_in         = mem_rsp_data;
        ir_wr         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = pc_q;
        instr_valid   = 1'b0;
        fault         = 1'b0;

        // A redirect seen while a fetch is in flight is remembered until the response retires it
        if ((state == S_REQ || state == S_WAIT) && redirect_valid) begin
            redir_pend_n = 1'b1;
            redir_pc_n   = redirect_pc;
        end

        case (state)
            S_BOOT: begin
                pc_in   = RESET_PC;
                pc_wr   = 1'b1;
                state_n = S_REQ;
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_n  = S_WAIT;
                    squash_n = redir_pend | redirect_valid;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    if (squash || redir_pend || redirect_valid) begin
                        pc_in        = redirect_valid ? redirect_pc : redir_pc;
                        pc_wr        = 1'b1;
                        redir_pend_n = 1'b0;
                        squash_n     = 1'b0;
                        state_n      = S_REQ;
                    end else if (mem_rsp_err) begin
                        cause_n = 1'b0;
                        state_n = S_FAULT;
                    end else begin
                        ir_wr   = 1'b1;
                        state_n = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (redirect_valid) begin
                    pc_in   = redirect_pc;
                    pc_wr   = 1'b1;
                    state_n = S_REQ;
                end else if (instr_ready) begin
                    pc_in   = pc_q + XLEN'(4);
                    pc_wr   = 1'b1;
                    state_n = S_REQ;
                end
            end
            S_FAULT: begin
                fault = 1'b1;
                if (redirect_valid) begin
                    pc_in   = redirect_pc;
                    pc_wr   = 1'b1;
                    state_n = S_REQ;
                end
            end
            default: state_n = S_BOOT;
        endcase

        // Any misaligned PC write still lands in the PC but parks the sequencer in FAULT
        if (pc_wr && (pc_in[1:0] != 2'b00)) begin
            cause_n = 1'b1;
            state_n = S_FAULT;
        end

        if (!rstn) begin
            pc_wr         = 1'b0;
            ir_wr         = 1'b0;
            mem_req_valid = 1'b0;
            instr_valid   = 1'b0;
            fault         = 1'b0;
        end
    end

    assign fault_cause = cause_q;

endmodule
